// File: rtl/param_mul_reconstruct.sv
// Iterative shift-add multiplier that rebuilds a dividend from the divider's
// outputs: dividend = quotient * divisor + remainder (unsigned).
// One multiplier bit is consumed per MUL cycle, so an operation takes WIDTH cycles.
module param_mul_reconstruct #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dividend,
  output logic                 overflow,
  output logic                 rem_err
);

  // Counter must reach WIDTH after the last increment, hence WIDTH+1 values.
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } state_e;

  state_e               r_state;
  state_e               w_state_d;
  logic                 w_capture;
  logic                 w_last;

  logic [WIDTH-1:0]     r_quot;
  logic [WIDTH-1:0]     r_div;
  logic [WIDTH-1:0]     r_rem;
  logic [CntW-1:0]      r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_dividend;
  logic                 r_overflow;
  logic                 r_rem_err;

  logic [WIDTH-1:0]     w_quot_shift;
  logic                 w_bit;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;

  // Partial product for the current counter position.
  always_comb begin
    w_quot_shift = r_quot >> r_cnt;
    w_bit        = w_quot_shift[0];
    w_addend     = '0;
    if (w_bit) begin
      w_addend = {{WIDTH{1'b0}}, r_div} << r_cnt;
    end
    w_acc_next = r_acc + w_addend;
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    w_state_d = r_state;
    w_capture = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StMul;
          w_capture = 1'b1;
        end
      end
      StMul: begin
        if (r_cnt == LastCnt) begin
          w_state_d = StDone;
          w_last    = 1'b1;
        end
      end
      StDone: begin
        if (start) begin
          w_state_d = StMul;
          w_capture = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Operand capture, accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quot     <= '0;
      r_div      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_dividend <= '0;
      r_overflow <= 1'b0;
      r_rem_err  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_quot <= quotient;
        r_div  <= divisor;
        r_rem  <= remainder;
        r_cnt  <= '0;
        r_acc  <= {{WIDTH{1'b0}}, remainder};
      end else if (r_state == StMul) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CntW'(1);
      end
      // Results land on the DONE entry edge and hold until the next one.
      if (w_last) begin
        r_dividend <= w_acc_next;
        r_overflow <= |w_acc_next[2*WIDTH-1:WIDTH];
        r_rem_err  <= (r_rem >= r_div);
      end
    end
  end

  // DONE lasts exactly one cycle, so decoding it gives the single-cycle pulse.
  always_comb begin
    busy     = (r_state == StMul);
    done     = (r_state == StDone);
    dividend = r_dividend;
    overflow = r_overflow;
    rem_err  = r_rem_err;
  end

endmodule

// File: tb/tb_param_mul_reconstruct.sv
// Self-checking bench for param_mul_reconstruct at WIDTH=8: table of vectors,
// scoreboard queue checked on every done pulse, plus hand-written corner cases.
module tb_param_mul_reconstruct;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0]   q;
    logic [W-1:0]   d;
    logic [W-1:0]   r;
    logic [2*W-1:0] dv;
    logic           ov;
    logic           re;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   quotient = '0;
  logic [W-1:0]   divisor = '0;
  logic [W-1:0]   remainder = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] dividend;
  logic           overflow;
  logic           rem_err;

  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;
  vec_t exp_q[$];
  vec_t tbl[$];

  param_mul_reconstruct #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dividend  (dividend),
    .overflow  (overflow),
    .rem_err   (rem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int q, input int d, input int r, input int dv, input int ov,
                              input int re);
    vec_t v;
    v.q  = W'(q);
    v.d  = W'(d);
    v.r  = W'(r);
    v.dv = (2*W)'(dv);
    v.ov = ov[0];
    v.re = re[0];
    return v;
  endfunction

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_not_consecutive", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done actual=dividend %0d required=no_done", dividend);
      end else begin
        vec_t e;
        logic [2*W-1:0] sum;
        e = exp_q.pop_front();
        sum = (2*W)'(e.q) * (2*W)'(e.d) + (2*W)'(e.r);
        chk("dividend", {16'd0, dividend}, {16'd0, e.dv});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
        chk("rem_err", {31'd0, rem_err}, {31'd0, e.re});
        chk("identity", {16'd0, dividend}, {16'd0, sum});
      end
    end
    prev_done = rst ? 1'b0 : done;
  end

  // Counts negedges until done; lat stays 0 if done never shows up.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    int nbusy;
    @(posedge clk); #1;
    start = 1'b1;
    quotient = v.q;
    divisor = v.d;
    remainder = v.r;
    exp_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble operands during MUL; they must not matter.
    quotient = W'($urandom);
    divisor = W'($urandom);
    remainder = W'($urandom);
    wait_done(lat, nbusy);
    chk("latency", lat, 9);
    chk("busy_cycles", nbusy, 8);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("hold_dividend", {16'd0, dividend}, {16'd0, v.dv});
  endtask

  initial begin
    int lat;
    int nbusy;

    tbl.push_back(mk(12, 5, 3, 63, 0, 0));
    tbl.push_back(mk(255, 255, 254, 65279, 1, 0));
    tbl.push_back(mk(7, 0, 4, 4, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 255, 255, 510, 1, 1));
    tbl.push_back(mk(16, 16, 0, 256, 1, 0));
    tbl.push_back(mk(255, 1, 0, 255, 0, 0));
    tbl.push_back(mk(0, 200, 199, 199, 0, 0));
    tbl.push_back(mk(15, 17, 16, 271, 1, 0));
    tbl.push_back(mk(128, 2, 1, 257, 1, 0));

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dividend", {16'd0, dividend}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_rem_err", {31'd0, rem_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i]);

    // Start while busy is ignored.
    @(posedge clk); #1;
    start = 1'b1; quotient = 8'd12; divisor = 8'd5; remainder = 8'd3;
    exp_q.push_back(mk(12, 5, 3, 63, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; quotient = 8'd1; divisor = 8'd1; remainder = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nbusy);
    chk("busy_start_latency", lat, 6);
    repeat (14) @(negedge clk);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Reset during the 4th MUL cycle.
    @(posedge clk); #1;
    start = 1'b1; quotient = 8'd12; divisor = 8'd5; remainder = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_dividend", {16'd0, dividend}, 32'd0);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    run_op(mk(2, 3, 1, 7, 0, 0));

    // Back-to-back: new start presented during the DONE cycle.
    @(posedge clk); #1;
    start = 1'b1; quotient = 8'd12; divisor = 8'd5; remainder = 8'd3;
    exp_q.push_back(mk(12, 5, 3, 63, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nbusy);
    chk("b2b_first_latency", lat, 9);
    start = 1'b1; quotient = 8'd10; divisor = 8'd10; remainder = 8'd9;
    exp_q.push_back(mk(10, 10, 9, 109, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nbusy);
    chk("b2b_second_latency", lat, 9);
    chk("b2b_busy_between", nbusy, 8);
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
